// File: rtl/ex_mem.sv
// EX->MEM pipeline register with HI/LO request and loop-back of execute's multi-cycle accumulate state.
// Latency 1 cycle, all outputs registered; flush > bubble (stall[3] only) > hold (stall[3]&stall[4]) > capture.
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                ex_valid_i,
  input  logic [ADDR_W-1:0]   ex_wd_i,
  input  logic                ex_wreg_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_whilo_i,
  input  logic [DATA_W-1:0]   ex_hi_i,
  input  logic [DATA_W-1:0]   ex_lo_i,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [1:0]          cnt_i,
  output logic                mem_valid_o,
  output logic [ADDR_W-1:0]   mem_wd_o,
  output logic                mem_wreg_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic                mem_whilo_o,
  output logic [DATA_W-1:0]   mem_hi_o,
  output logic [DATA_W-1:0]   mem_lo_o,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [1:0]          cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } pipe_t;

  pipe_t               pipe_q, pipe_d, pipe_in;
  logic [2*DATA_W-1:0] hilo_temp_q, hilo_temp_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                ex_stall, mem_stall;

  assign ex_stall  = stall[3];
  assign mem_stall = stall[4];

  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = ex_valid_i;
    pipe_in.wd    = ex_wd_i;
    pipe_in.wreg  = ex_wreg_i;
    pipe_in.wdata = ex_wdata_i;
    pipe_in.whilo = ex_whilo_i;
    pipe_in.hi    = ex_hi_i;
    pipe_in.lo    = ex_lo_i;
  end

  // Illegal stall[3]=0/stall[4]=1 falls through to capture.
  always_comb begin
    pipe_d      = pipe_q;
    hilo_temp_d = hilo_temp_q;
    cnt_d       = cnt_q;
    if (flush) begin
      pipe_d      = '0;
      hilo_temp_d = '0;
      cnt_d       = '0;
    end else if (ex_stall && !mem_stall) begin
      pipe_d      = '0;
      hilo_temp_d = hilo_temp_i;
      cnt_d       = cnt_i;
    end else if (ex_stall && mem_stall) begin
      pipe_d      = pipe_q;
    end else begin
      pipe_d      = pipe_in;
      hilo_temp_d = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q      <= '0;
      hilo_temp_q <= '0;
      cnt_q       <= '0;
    end else begin
      pipe_q      <= pipe_d;
      hilo_temp_q <= hilo_temp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_valid_o = pipe_q.valid;
  assign mem_wd_o    = pipe_q.wd;
  assign mem_wreg_o  = pipe_q.wreg;
  assign mem_wdata_o = pipe_q.wdata;
  assign mem_whilo_o = pipe_q.whilo;
  assign mem_hi_o    = pipe_q.hi;
  assign mem_lo_o    = pipe_q.lo;
  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;

  a_no_mem_only_stall: assert property (@(posedge clk) disable iff (!rst) !(mem_stall && !ex_stall));

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: reset, capture, bubble/loop-back, hold, flush priority, back-to-back.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic        ex_whilo_i;
  logic [31:0] ex_hi_i;
  logic [31:0] ex_lo_i;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic        mem_valid_o;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic        mem_whilo_o;
  logic [31:0] mem_hi_o;
  logic [31:0] mem_lo_o;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int total = 0;
  int bad   = 0;

  // {valid, wd, wreg, wdata, whilo, hi, lo}
  logic [103:0] obs;
  assign obs = {mem_valid_o, mem_wd_o, mem_wreg_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o};

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid_i(ex_valid_i), .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i),
    .ex_wdata_i(ex_wdata_i), .ex_whilo_i(ex_whilo_i), .ex_hi_i(ex_hi_i),
    .ex_lo_i(ex_lo_i), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_valid_o(mem_valid_o), .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o),
    .mem_wdata_o(mem_wdata_o), .mem_whilo_o(mem_whilo_o), .mem_hi_o(mem_hi_o),
    .mem_lo_o(mem_lo_o), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic whilo,
                       input logic [31:0] hi, input logic [31:0] lo);
    ex_valid_i = v; ex_wd_i = wd; ex_wreg_i = wreg; ex_wdata_i = wdata;
    ex_whilo_i = whilo; ex_hi_i = hi; ex_lo_i = lo;
  endtask

  task automatic test_reset();
    logic [103:0] exp_full;
    #1;
    total++;
    if (obs !== 104'd0 || hilo_temp_o !== 64'd0 || cnt_o !== 2'd0) begin
      $display("FAIL reset_initial obs=%h hilo=%h cnt=%0d want all 0", obs, hilo_temp_o, cnt_o); bad++;
    end
    drive(1'b1, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 32'h11, 32'h22);
    stall = 6'b000000;
    #2 rst = 1'b1;
    step();
    exp_full = {1'b1, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 32'h11, 32'h22};
    total++;
    if (obs !== exp_full) begin
      $display("FAIL reset_pre_capture obs=%h want %h", obs, exp_full); bad++;
    end
    #3 rst = 1'b0;
    #1;
    total++;
    if (obs !== 104'd0) begin
      $display("FAIL reset_async_pipe obs=%h want 0", obs); bad++;
    end
    #1 rst = 1'b1;
    stall = 6'b001111; hilo_temp_i = 64'hCAFE_0000_0000_BEEF; cnt_i = 2'd2;
    step();
    total++;
    if (cnt_o !== 2'd2 || hilo_temp_o !== 64'hCAFE_0000_0000_BEEF) begin
      $display("FAIL reset_pre_loopback cnt=%0d hilo=%h want 2 / cafe00000000beef", cnt_o, hilo_temp_o); bad++;
    end
    #3 rst = 1'b0;
    #1;
    total++;
    if (cnt_o !== 2'd0 || hilo_temp_o !== 64'd0) begin
      $display("FAIL reset_async_loopback cnt=%0d hilo=%h want 0", cnt_o, hilo_temp_o); bad++;
    end
    #1 rst = 1'b1;
    stall = 6'b000000; cnt_i = 2'd0; hilo_temp_i = 64'd0;
  endtask

  task automatic test_capture();
    logic [103:0] exp_v;
    stall = 6'b000000;
    drive(1'b1, 5'd8, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1, 32'h2);
    step();
    exp_v = {1'b1, 5'd8, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1, 32'h2};
    total++;
    if (obs !== exp_v) begin
      $display("FAIL capture obs=%h want %h", obs, exp_v); bad++;
    end
    // invalid slot still captured as presented, but marks the slot empty
    drive(1'b0, 5'd9, 1'b0, 32'h0000_0077, 1'b0, 32'h5, 32'h6);
    step();
    exp_v = {1'b0, 5'd9, 1'b0, 32'h0000_0077, 1'b0, 32'h5, 32'h6};
    total++;
    if (obs !== exp_v) begin
      $display("FAIL capture_invalid obs=%h want %h", obs, exp_v); bad++;
    end
  endtask

  task automatic test_bubble_loopback();
    stall = 6'b000000;
    drive(1'b1, 5'd4, 1'b1, 32'h55, 1'b1, 32'h7, 32'h8);
    step();
    stall = 6'b001111; hilo_temp_i = 64'h0000_0001_FFFF_FFFF; cnt_i = 2'd1;
    step();
    total++;
    if (obs !== 104'd0) begin
      $display("FAIL bubble_fields obs=%h want 0", obs); bad++;
    end
    total++;
    if (hilo_temp_o !== 64'h0000_0001_FFFF_FFFF || cnt_o !== 2'd1) begin
      $display("FAIL bubble_loopback hilo=%h cnt=%0d want 00000001ffffffff / 1", hilo_temp_o, cnt_o); bad++;
    end
    stall = 6'b000000; hilo_temp_i = 64'h1234; cnt_i = 2'd3;
    step();
    total++;
    if (hilo_temp_o !== 64'd0 || cnt_o !== 2'd0 || mem_valid_o !== 1'b1) begin
      $display("FAIL bubble_then_capture hilo=%h cnt=%0d valid=%b want 0/0/1", hilo_temp_o, cnt_o, mem_valid_o); bad++;
    end
    // hold must also freeze the loop-back registers
    stall = 6'b001111; cnt_i = 2'd3; hilo_temp_i = 64'hAAAA;
    step();
    stall = 6'b011111; cnt_i = 2'd0; hilo_temp_i = 64'h0;
    step();
    total++;
    if (cnt_o !== 2'd3 || hilo_temp_o !== 64'hAAAA) begin
      $display("FAIL hold_loopback cnt=%0d hilo=%h want 3 / aaaa", cnt_o, hilo_temp_o); bad++;
    end
    stall = 6'b000000; hilo_temp_i = 64'd0;
    step();
  endtask

  task automatic test_hold();
    logic [103:0] exp_v;
    stall = 6'b000000;
    drive(1'b1, 5'd17, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h3, 32'h4);
    step();
    exp_v = {1'b1, 5'd17, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h3, 32'h4};
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 20), 1'b0, 32'h100 + 32'(i), 1'b1, 32'h9, 32'h9);
      step();
      total++;
      if (obs !== exp_v) begin
        $display("FAIL hold_cycle%0d obs=%h want %h", i, obs, exp_v); bad++;
      end
    end
    stall = 6'b000000;
    drive(1'b1, 5'd30, 1'b1, 32'h0BAD_F00D, 1'b1, 32'hAB, 32'hCD);
    step();
    exp_v = {1'b1, 5'd30, 1'b1, 32'h0BAD_F00D, 1'b1, 32'hAB, 32'hCD};
    total++;
    if (obs !== exp_v) begin
      $display("FAIL hold_release obs=%h want %h", obs, exp_v); bad++;
    end
  endtask

  task automatic test_flush();
    stall = 6'b001111; cnt_i = 2'd1; hilo_temp_i = 64'h77;
    step();
    total++;
    if (cnt_o !== 2'd1) begin
      $display("FAIL flush_setup cnt=%0d want 1", cnt_o); bad++;
    end
    flush = 1'b1; stall = 6'b011111;
    step();
    total++;
    if (obs !== 104'd0 || cnt_o !== 2'd0 || hilo_temp_o !== 64'd0) begin
      $display("FAIL flush_over_hold_loopback obs=%h cnt=%0d hilo=%h want 0", obs, cnt_o, hilo_temp_o); bad++;
    end
    flush = 1'b0; stall = 6'b000000; cnt_i = 2'd0; hilo_temp_i = 64'd0;
    drive(1'b1, 5'd2, 1'b1, 32'hFEED, 1'b1, 32'h1, 32'h1);
    step();
    flush = 1'b1; stall = 6'b011111;
    step();
    total++;
    if (obs !== 104'd0) begin
      $display("FAIL flush_over_hold_pipe obs=%h want 0", obs); bad++;
    end
    stall = 6'b000000;
    step();
    total++;
    if (obs !== 104'd0) begin
      $display("FAIL flush_over_capture obs=%h want 0", obs); bad++;
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    stall = 6'b000000;
    drive(1'b1, 5'd1, 1'b1, 32'd1, 1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (mem_wdata_o !== 32'(i) || mem_valid_o !== 1'b1) begin
        $display("FAIL b2b_%0d wdata=%0d valid=%b want %0d / 1", i, mem_wdata_o, mem_valid_o, i); bad++;
      end
      ex_wdata_i = 32'(i + 1);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = 6'b000000;
    hilo_temp_i = 64'd0; cnt_i = 2'd0;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_capture();
    test_bubble_loopback();
    test_hold();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. Captures the execute result each cycle: destination register, write enable, write data, and HI/LO write request. Honours the global stall vector and a flush request. Also holds the multi-cycle accumulate state (`hilo_temp`, `cnt`) that execute loops back to itself while it is stalled. Its registered HI/LO outputs also serve as the memory-stage forwarding source for execute's HI/LO bypass.

## Interface
- `DATA_W`, 32, GPR and HI/LO width
- `ADDR_W`, 5, GPR address width
- `STALL_W`, 6, stall vector width; bit order [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall`  in  STALL_W  global stall vector from the stall controller
- `flush`  in  1  synchronous pipeline flush (exception/redirect)
- `ex_valid_i`  in  1  execute slot holds a real instruction
- `ex_wd_i`  in  ADDR_W  destination GPR
- `ex_wreg_i`  in  1  GPR write enable
- `ex_wdata_i`  in  DATA_W  GPR write data
- `ex_whilo_i`  in  1  HI/LO write enable
- `ex_hi_i`, `ex_lo_i`  in  DATA_W  HI/LO write values
- `hilo_temp_i`  in  2*DATA_W  partial multiply-accumulate result from execute
- `cnt_i`  in  2  execute multi-cycle step counter
- `mem_valid_o`  out  1  memory slot holds a real instruction
- `mem_wd_o`  out  ADDR_W
- `mem_wreg_o`  out  1
- `mem_wdata_o`  out  DATA_W
- `mem_whilo_o`  out  1
- `mem_hi_o`, `mem_lo_o`  out  DATA_W
- `hilo_temp_o`  out  2*DATA_W  loop-back of saved partial result to execute
- `cnt_o`  out  2  loop-back of saved step counter to execute

## Operation
- All outputs are registered. No combinational path from any input to any output.
- Per-cycle action, highest priority first:
  - **Flush** (`flush`=1): load bubble into the pipeline fields; clear `hilo_temp_o` and `cnt_o` to 0.
  - **Bubble** (`stall[3]`=1, `stall[4]`=0): load bubble into the pipeline fields. Capture `hilo_temp_i` into `hilo_temp_o` and `cnt_i` into `cnt_o`. Execute is holding its instruction, so no instruction advances.
  - **Hold** (`stall[3]`=1, `stall[4]`=1): all registers keep their values, including loop-back.
  - **Capture** (`stall[3]`=0): load all `ex_*_i` into the `mem_*_o` registers. Clear `hilo_temp_o` and `cnt_o` to 0, because the accumulate sequence completed and advanced.
- Bubble definition: `mem_valid_o`=0, `mem_wd_o`=0, `mem_wreg_o`=0, `mem_wdata_o`=0, `mem_whilo_o`=0, `mem_hi_o`=0, `mem_lo_o`=0.
- `stall[3]`=0 with `stall[4]`=1 is illegal from the stall controller. If it occurs, the block performs Capture. Verification flags it with an assertion only.
- No filtering on `ex_valid_i`. When `ex_valid_i`=0, the other inputs are still captured as presented. Execute guarantees write enables are 0 for invalid slots.
- Effective 2-state machine per slot, encoded by `mem_valid_o`: EMPTY and FULL.
  - EMPTY→FULL on Capture with `ex_valid_i`=1.
  - FULL→EMPTY on Flush, Bubble, or Capture with `ex_valid_i`=0.
  - Hold keeps the current state.

## Timing
- Reset (`rst` low, asynchronous assertion): all outputs go to 0 immediately, independent of `clk`.
- Reset release: synchronous to the next rising edge, via the standard reset synchroniser upstream. The first active edge after release applies the normal action table.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Loop-back: `hilo_temp_o`/`cnt_o` written at edge N are visible to execute during cycle N+1. This supports a 2-cycle accumulate: cnt 0→1 in the stalled cycle, then completion.
- Reset mid-sequence: a nonzero `cnt_o` is cleared asynchronously. Execute restarts from cnt=0.
- Flush coincident with any stall pattern: flush wins.
- Flush coincident with `rst` low: reset wins.

## Test plan
- **Reset:** drive inputs nonzero, pulse `rst` low mid-cycle → all outputs 0 before the next edge, including `hilo_temp_o` and `cnt_o`.
- **Capture:** `stall`=6'b000000, `ex_valid_i`=1, wd=5'd8, wreg=1, wdata=32'hDEADBEEF, whilo=1, hi=32'h1, lo=32'h2 → next cycle outputs equal inputs, `mem_valid_o`=1.
- **Bubble with loop-back:** `stall`=6'b001111, `hilo_temp_i`=64'h0000_0001_FFFF_FFFF, `cnt_i`=2'd1 → `mem_valid_o`=0, `mem_wreg_o`=0, `mem_whilo_o`=0; `hilo_temp_o`=64'h0000_0001_FFFF_FFFF, `cnt_o`=1. Following Capture cycle → `cnt_o`=0, `hilo_temp_o`=0.
- **Hold:** after capturing wdata=32'hA5A5A5A5, apply `stall`=6'b011111 for 3 cycles while changing inputs → outputs stay 32'hA5A5A5A5, valid=1. Release → new inputs captured one edge later.
- **Flush priority:** `flush`=1 together with `stall`=6'b011111 and `cnt_o`=1 → next cycle full bubble and `cnt_o`=0.
- **Back-to-back:** 4 consecutive Capture cycles with wdata 1,2,3,4 → `mem_wdata_o` shows 1,2,3,4 on consecutive cycles with no gaps.
